sccb_config: RTL
================

# sccb_config

Camera register-configuration master: the transmit side of the camera link, complementing the pixel receive path. After a `start` pulse it walks an internal register table and issues one SCCB 3-phase write (device ID, sub-address, data) per entry on the camera's SIOC/SIOD pins. It sits between the top level and the Arduino-header camera pins, and must finish before `camera_read` data is trusted.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency.
- `SCCB_HZ`, 100_000, SIOC bit rate.
- `DEV_ID`, 8'h42, camera write address (ID byte sent verbatim, R/W bit = 0).
- `DELAY_MS`, 10, wait length for a delay table entry.

Ports:
- `Clk` input 1: system clock (50 MHz).
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: single-cycle pulse; begins table walk when idle, ignored when busy.
- `busy` output 1: high from the cycle after an accepted `start` until `done` is asserted.
- `done` output 1: level, high after terminator reached; cleared by next accepted `start`.
- `ack_err` output 1: sticky error flag (see Configuration); cleared by accepted `start`.
- `sioc` output 1: SCCB clock, driven push-pull.
- `siod_o` output 1: SIOD drive value (always 0 when `siod_oe`=1).
- `siod_oe` output 1: SIOD drive enable; 0 = released (pulled high externally).
- `siod_i` input 1: SIOD sampled value.

## Operation
- Quarter-bit tick: divider counts 0..Q-1, Q = CLK_HZ/(4*SCCB_HZ) (125 at defaults); all bus edges land on ticks. Divider held at 0 in IDLE/DONE.
- Open-drain signalling: logical 1 → `siod_oe`=0; logical 0 → `siod_oe`=1, `siod_o`=0.
- Table (16-bit {addr,data}, index 8 bits): 0:{12,80} (COM7 soft reset), 1:{FF,F0} delay marker, 2:{12,04} (RGB), 3:{40,D0} (RGB565, full range), 4:{8C,00}, 5:{3A,04}, 6:{FF,FF} terminator. Extra entries may be inserted before the terminator.
- FSM states: IDLE, FETCH, START, BYTE, STOP, GAP, WAIT, DONE.
  - IDLE --start--> FETCH (index=0).
  - FETCH: entry FFFF → DONE; FFF0 → WAIT; else → START.
  - START (4 ticks): SIOD low while SIOC high (tick 1), SIOC low (tick 2), hold.
  - BYTE: 3 phases × 9 bits, MSB first: DEV_ID, addr, data. Per bit: tick0 set SIOD with SIOC low, tick1 SIOC high, tick2 sample `siod_i` (9th bit only), tick3 SIOC low. 9th bit: SIOD released.
  - STOP (4 ticks): SIOD low, SIOC high, then SIOD released.
  - GAP: 4 ticks bus idle (SIOC=1, released) → FETCH with index+1.
  - WAIT: DELAY_MS × CLK_HZ/1000 cycles, bus idle → FETCH with index+1.
  - DONE: bus idle; `start` → FETCH, restarts from index 0.
- `start` during any non-IDLE/DONE state: ignored, no effect.
- Index saturates at 255; reaching 255 without a terminator forces DONE.

## Timing
- Reset values: `sioc`=1, `siod_oe`=0, `siod_o`=0, `busy`=0, `done`=0, `ack_err`=0, state IDLE, index 0.
- Reset asserted mid-transaction: next edge returns all outputs to reset values same cycle (bus released, SIOC high); no stop condition generated.
- Accepted `start` at edge N → `busy`=1 at N+1; first SIOD fall at tick 1 of START.
- One write = 4 (START) + 108 (27 bits) + 4 (STOP) + 4 (GAP) = 120 ticks = 300 µs at defaults.
- `done` and `busy`=0 assert in the same cycle FETCH reads FFFF.
- SIOD changes only while SIOC low, except start/stop edges.

## Configuration
- `SCCB_ACK_CHECK_EN` defined: 9th-bit sample of each phase must be 0; a 1 sets `ack_err` (sticky) and the transaction still completes with STOP; the walk continues.
- Undefined: 9th bit sampled but ignored (SCCB don't-care); `ack_err` tied 0.

## Test plan
- Reset then idle 1000 cycles → `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0 throughout.
- `start` pulse, bus model decodes → writes in order {42,12,80}, {42,12,04}, {42,40,D0}, {42,8C,00}, {42,3A,04}; `done`=1; write 0 start-to-stop 116 ticks.
- Measure gap between write 0 STOP and write 1 START → ≥ 500_000 cycles (10 ms delay); SIOC frequency 100 kHz ±1 cycle.
- With `SCCB_ACK_CHECK_EN`, slave model NACKs data phase of entry 3 → `ack_err`=1, remaining writes still issued, `done`=1; new `start` clears `ack_err`.
- `start` pulsed during write 2 → no restart, sequence unchanged; `rst_n`=0 mid-byte → next cycle `siod_oe`=0, `sioc`=1, `busy`=0.
- After `done`, second `start` → full sequence repeats from {42,12,80}, `done` low while busy.

Source files
------------

// File: rtl/sccb_config.sv
// sccb_config: camera register-configuration master.
// After a start pulse it walks an internal {addr,data} table and issues one
// SCCB 3-phase write (DEV_ID, addr, data) per entry on SIOC/SIOD.
// Optional build macro SCCB_ACK_CHECK_EN: a 1 sampled in the 9th bit of any
// phase sets the sticky ack_err flag. Without it the 9th bit is ignored and
// ack_err is tied low.
module sccb_config #(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         SCCB_HZ  = 100_000,
    parameter logic [7:0] DEV_ID   = 8'h42,
    parameter int         DELAY_MS = 10
) (
    input  logic Clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic ack_err,
    output logic sioc,
    output logic siod_o,
    output logic siod_oe,
    input  logic siod_i
);

    // Quarter-bit divider length and delay-entry length in system clocks
    localparam int Q        = CLK_HZ / (4 * SCCB_HZ);
    localparam int DIV_W    = (Q > 1) ? $clog2(Q) : 1;
    localparam int WAIT_CYC = DELAY_MS * (CLK_HZ / 1000);
    localparam int WAIT_W   = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_BYTE, S_STOP, S_GAP, S_WAIT, S_DONE
    } state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [1:0]        qtr;
    logic [3:0]        bit_idx;
    logic [1:0]        phase;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        idx;
    logic [15:0]       entry;
    logic [7:0]        cur_byte;
    logic [2:0]        bit_sel;
    logic              tick;
    logic              bus_active;
    logic              accept;
    logic              slot_end;
    logic              wait_end;
    logic              sioc_d;
    logic              sda_low_d;

    // Register table: {sub-address, data}; FFF0 = delay marker, FFFF = end.
    // New entries go before the terminator.
    function automatic logic [15:0] table_entry(input logic [7:0] i);
        case (i)
            8'd0:    return 16'h1280;  // COM7 soft reset
            8'd1:    return 16'hFFF0;  // let the sensor come out of reset
            8'd2:    return 16'h1204;  // RGB output
            8'd3:    return 16'h40D0;  // RGB565, full range
            8'd4:    return 16'h8C00;
            8'd5:    return 16'h3A04;
            default: return 16'hFFFF;
        endcase
    endfunction

    assign entry      = table_entry(idx);
    assign tick       = (div_cnt == DIV_W'(Q - 1));
    assign bus_active = (state == S_START) || (state == S_BYTE) ||
                        (state == S_STOP)  || (state == S_GAP);
    assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
    assign slot_end   = tick && (qtr == 2'd3);
    assign wait_end   = (wait_cnt == WAIT_W'(WAIT_CYC - 1));
    assign bit_sel    = 3'd7 - bit_idx[2:0];
    assign siod_o     = 1'b0;

    always_comb begin
        case (phase)
            2'd0:    cur_byte = DEV_ID;
            2'd1:    cur_byte = entry[15:8];
            default: cur_byte = entry[7:0];
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next state and per-quarter bus levels (bus idle unless a state says otherwise)
    always_comb begin
        state_next = state;
        sioc_d     = 1'b1;
        sda_low_d  = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_FETCH;
            S_FETCH: begin
                if (entry == 16'hFFFF || idx == 8'hFF) state_next = S_DONE;
                else if (entry == 16'hFFF0)            state_next = S_WAIT;
                else                                   state_next = S_START;
            end
            S_START: begin
                // q0 idle, q1 SIOD falls under high SIOC, q2 SIOC falls, q3 hold
                sda_low_d = (qtr != 2'd0);
                sioc_d    = (qtr < 2'd2);
                if (slot_end) state_next = S_BYTE;
            end
            S_BYTE: begin
                // SIOC high in q1..q2; data set in q0 while SIOC is low
                sioc_d    = (qtr == 2'd1) || (qtr == 2'd2);
                sda_low_d = (bit_idx != 4'd8) && !cur_byte[bit_sel];
                if (slot_end && bit_idx == 4'd8 && phase == 2'd2) state_next = S_STOP;
            end
            S_STOP: begin
                // q0 SIOD low/SIOC low, q1 SIOC high, q2 SIOD released (stop), q3 idle
                sioc_d    = (qtr != 2'd0);
                sda_low_d = (qtr < 2'd2);
                if (slot_end) state_next = S_GAP;
            end
            S_GAP:  if (slot_end) state_next = S_FETCH;
            S_WAIT: if (wait_end) state_next = S_FETCH;
            S_DONE: if (start) state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    // Quarter-bit divider, bit/phase position, delay counter and table index
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            qtr      <= 2'd0;
            bit_idx  <= 4'd0;
            phase    <= 2'd0;
            wait_cnt <= '0;
            idx      <= 8'd0;
        end else begin
            if (bus_active && !tick) div_cnt <= div_cnt + 1'b1;
            else                     div_cnt <= '0;

            if (!bus_active) qtr <= 2'd0;
            else if (tick)   qtr <= qtr + 2'd1;

            if (state != S_BYTE) begin
                bit_idx <= 4'd0;
                phase   <= 2'd0;
            end else if (slot_end) begin
                if (bit_idx == 4'd8) begin
                    bit_idx <= 4'd0;
                    phase   <= phase + 2'd1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                end
            end

            if (state == S_WAIT && !wait_end) wait_cnt <= wait_cnt + 1'b1;
            else                              wait_cnt <= '0;

            if (accept)
                idx <= 8'd0;
            else if ((state == S_GAP && slot_end) || (state == S_WAIT && wait_end))
                idx <= (idx == 8'hFF) ? idx : idx + 8'd1;
        end
    end

    // Registered pin levels and status flags
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            sioc    <= sioc_d;
            siod_oe <= sda_low_d;
            if (accept) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (state == S_FETCH && state_next == S_DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    logic ack_sample;
    assign ack_sample = (state == S_BYTE) && tick && (qtr == 2'd2) && (bit_idx == 4'd8);

    // Sticky flag for a released (high) 9th bit; the walk carries on regardless
    always_ff @(posedge Clk) begin
        if (!rst_n)                    ack_err <= 1'b0;
        else if (accept)               ack_err <= 1'b0;
        else if (ack_sample && siod_i) ack_err <= 1'b1;
    end
`else
    // 9th bit is an SCCB don't-care in this build
    logic unused_siod_i;
    assign unused_siod_i = siod_i;
    assign ack_err       = 1'b0;
`endif

endmodule
